utf8_putc: RTL and testbench
============================

Name: utf8_putc

Overview:
- Downstream companion stage of the UTF-8 decoder component: it consumes a decoded code point and re-encodes it as a 1-4 byte UTF-8 sequence.
- The encoded bytes are written to byte-addressed memory through an Avalon-MM write master.
- Call/return handshake and return codes are identical in style to the decoder, so the two stages chain directly.
- Return codes: byte count; -1 if the buffer is too short; -2 if the value cannot be encoded.

Parameters:
ADDR_W, 64, byte address width of str and avmm address
DATA_W, 64, avmm data width; byte lanes = DATA_W/8 (power of two, >= 8)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  call.valid; request accepted when start=1 and busy=0
busy  out  1  call.stall; high whenever state != IDLE
done  out  1  return.valid
stall  in  1  return.stall; done/returndata held while stall=1
returndata  out  32  signed result: 1..4 bytes written, -1 short buffer, -2 invalid value
str  in  ADDR_W  destination byte address; 0 = length query only, no writes
len  in  32  signed space available at str
value  in  32  code point to encode
avmm_0_rw_address  out  ADDR_W  byte address of current write
avmm_0_rw_byteenable  out  DATA_W/8  one-hot lane = address mod (DATA_W/8)
avmm_0_rw_write  out  1  write strobe
avmm_0_rw_writedata  out  DATA_W  encoded byte replicated on all lanes
avmm_0_rw_waitrequest  in  1  slave stall; hold write and all write signals while high

Behaviour:
- Interface (decided): one clock, clock; reset is asynchronous, active-high, port reset.
- Reset values: state=IDLE; busy=0, done=0, returndata=0, write=0, address=0, byteenable=0, writedata=0.
- Reset asserted at any time, including mid-write, returns to IDLE immediately. A partially written sequence is abandoned; no further writes are issued.
- FSM states: IDLE, CALC, WRITE, DONE.
- IDLE:
  - start=1 at edge T latches str, len, value. Next state is CALC.
  - busy rises in cycle T+1.
- CALC (one cycle): compute n from value, unsigned:
  - < 0x80 -> n=1; < 0x800 -> n=2; < 0x10000 -> n=3; < 0x200000 -> n=4.
  - Otherwise invalid: returndata=-2 (0xFFFFFFFE), go to DONE.
  - Surrogates (0xD800-0xDFFF) and values 0x110000-0x1FFFFF are encoded normally; there is no range check beyond 0x1FFFFF.
  - Valid and str==0: returndata=n, go to DONE.
  - Valid and signed len < n (negative len included): returndata=-1 (0xFFFFFFFF), go to DONE.
  - Otherwise clear byte index i=0 and go to WRITE.
  - Check order is fixed: invalid, then null str, then length.
- Encoding (v = value):
  - n=1: v[6:0].
  - n=2: {110,v[10:6]}, {10,v[5:0]}.
  - n=3: {1110,v[15:12]}, {10,v[11:6]}, {10,v[5:0]}.
  - n=4: {11110,v[20:18]}, {10,v[17:12]}, {10,v[11:6]}, {10,v[5:0]}.
- WRITE:
  - Drive write=1, address=str+i (mod 2^ADDR_W, wraps), byteenable=1<<(address mod lanes), writedata=byte i on every lane.
  - waitrequest=1: hold every avmm output stable.
  - waitrequest=0: the byte is accepted. If i==n-1, returndata=n and go to DONE; else i++.
  - Writes are strictly in ascending address order, one byte per accepted beat, with no gaps when waitrequest=0.
  - write=0 in all states other than WRITE.
- DONE:
  - done=1, returndata stable, busy=1.
  - stall=0 -> IDLE next edge; stall=1 -> remain in DONE.
  - start is ignored while busy=1.
- Latency with start at T and no waitrequest:
  - Error or query paths: done in cycle T+2.
  - Successful encode: writes in cycles T+2..T+1+n, done in cycle T+2+n.
  - Each waitrequest cycle adds one cycle.
- Back-to-back calls: a new start is accepted in the first IDLE cycle after DONE exits. There is no overlap between calls.

Test Plan:
- value=0x41, str=0x1000, len=8 -> one write, addr 0x1000, be=0x01, byte 0x41; returndata=1; done at T+3.
- value=0x20AC, str=0x1006, len=3 -> bytes E2,82,AC at 0x1006/0x1007/0x1008, be 0x40,0x80,0x01; returndata=3.
- value=0x1F600, len=3 -> no writes, returndata=0xFFFFFFFF; value=0x1F600, len=4 -> F0,9F,98,80, returndata=4.
- value=0x200000 -> returndata=0xFFFFFFFE, no writes; value=0x7FF, str=0 -> returndata=2, no writes.
- value=0xE9, waitrequest high 3 cycles on beat 0 and stall=1 for 2 cycles at done -> avmm outputs held constant, bytes C3,A9 each written exactly once, done held 3 cycles.
- reset pulse during beat 1 of a 3-byte encode -> all outputs at reset values the same cycle, no further writes; next call completes normally.

Source files
------------

// File: rtl/utf8_putc_if.sv
`default_nettype none
// ============================================================================
//  Module      : utf8_putc_if
//  Description : Call/return handshake plus Avalon-MM write-master bundle of
//                the UTF-8 encoder stage.
//                master modport : environment side (caller and memory slave)
//                slave  modport : utf8_putc side
//  Signals     : start/busy       call handshake
//                done/stall       return handshake, returndata result
//                str/len/value    call arguments
//                avmm_0_rw_*      byte write master towards memory
//  Revision    : 1.0  initial release
// ============================================================================
interface utf8_putc_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic                  start;
   logic                  busy;
   logic                  done;
   logic                  stall;
   logic [31:0]           returndata;
   logic [ADDR_W-1:0]     str;
   logic [31:0]           len;
   logic [31:0]           value;
   logic [ADDR_W-1:0]     avmm_0_rw_address;
   logic [DATA_W/8-1:0]   avmm_0_rw_byteenable;
   logic                  avmm_0_rw_write;
   logic [DATA_W-1:0]     avmm_0_rw_writedata;
   logic                  avmm_0_rw_waitrequest;

   modport master (
      output start, stall, str, len, value, avmm_0_rw_waitrequest,
      input  busy, done, returndata,
      input  avmm_0_rw_address, avmm_0_rw_byteenable, avmm_0_rw_write,
      input  avmm_0_rw_writedata
   );

   modport slave (
      input  start, stall, str, len, value, avmm_0_rw_waitrequest,
      output busy, done, returndata,
      output avmm_0_rw_address, avmm_0_rw_byteenable, avmm_0_rw_write,
      output avmm_0_rw_writedata
   );
endinterface
`default_nettype wire

// File: rtl/utf8_putc.sv
`default_nettype none
// ============================================================================
//  Module      : utf8_putc
//  Description : Encodes one code point as a 1-4 byte UTF-8 sequence and
//                writes it, one byte per beat, through an Avalon-MM write
//                master. Returns the byte count, -1 when the buffer is too
//                short, -2 when the value is not encodable. str==0 is a
//                length query that performs no writes.
//  Ports       : clock, reset   clock and asynchronous active-high reset
//                bus (slave)    call/return handshake, arguments, avmm master
//  Revision    : 1.0  initial release
// ============================================================================
module utf8_putc #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic       clock,
   input  logic       reset,
   utf8_putc_if.slave bus
);
   localparam int          c_LANES       = DATA_W / 8;
   localparam logic [31:0] c_RET_SHORT   = 32'hFFFF_FFFF;
   localparam logic [31:0] c_RET_INVALID = 32'hFFFF_FFFE;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nx;

   logic [ADDR_W-1:0] r_str;
   logic [31:0]       r_len;
   logic [31:0]       r_value;
   logic [31:0]       r_ret;
   logic [1:0]        r_idx;

   logic              w_accept;
   logic              w_invalid;
   logic [2:0]        w_n;
   logic              w_last;
   logic [7:0]        w_byte;
   logic              w_write;
   logic [ADDR_W-1:0] w_addr;
   logic              w_ret_ld;
   logic [31:0]       w_ret_nx;
   logic              w_idx_clr;
   logic              w_idx_inc;

   assign w_accept = (r_state == S_IDLE) && bus.start;

   // Sequence length from the latched value; anything at or above 2^21 has
   // no 4-byte form and is reported as invalid.
   always_comb begin
      w_n       = 3'd0;
      w_invalid = 1'b0;
      if (r_value < 32'h0000_0080)
         w_n = 3'd1;
      else if (r_value < 32'h0000_0800)
         w_n = 3'd2;
      else if (r_value < 32'h0001_0000)
         w_n = 3'd3;
      else if (r_value < 32'h0020_0000)
         w_n = 3'd4;
      else
         w_invalid = 1'b1;
   end

   assign w_last = ({1'b0, r_idx} == (w_n - 3'd1));

   // Byte r_idx of the sequence; byte 0 is the lead byte.
   always_comb begin
      w_byte = 8'h00;
      case (w_n)
         3'd1: w_byte = {1'b0, r_value[6:0]};
         3'd2: begin
            if (r_idx == 2'd0) w_byte = {3'b110, r_value[10:6]};
            else               w_byte = {2'b10,  r_value[5:0]};
         end
         3'd3: begin
            case (r_idx)
               2'd0:    w_byte = {4'b1110, r_value[15:12]};
               2'd1:    w_byte = {2'b10,   r_value[11:6]};
               default: w_byte = {2'b10,   r_value[5:0]};
            endcase
         end
         3'd4: begin
            case (r_idx)
               2'd0:    w_byte = {5'b11110, r_value[20:18]};
               2'd1:    w_byte = {2'b10,    r_value[17:12]};
               2'd2:    w_byte = {2'b10,    r_value[11:6]};
               default: w_byte = {2'b10,    r_value[5:0]};
            endcase
         end
         default: w_byte = 8'h00;
      endcase
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nx;
   end

   // Next state and datapath controls
   always_comb begin
      w_state_nx = r_state;
      w_ret_ld   = 1'b0;
      w_ret_nx   = r_ret;
      w_idx_clr  = 1'b0;
      w_idx_inc  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_state_nx = S_CALC;
         end
         S_CALC: begin
            // Fixed precedence: invalid value, then length query, then space.
            w_ret_ld = 1'b1;
            if (w_invalid) begin
               w_ret_nx   = c_RET_INVALID;
               w_state_nx = S_DONE;
            end else if (r_str == '0) begin
               w_ret_nx   = {29'd0, w_n};
               w_state_nx = S_DONE;
            end else if ($signed(r_len) < $signed({29'd0, w_n})) begin
               w_ret_nx   = c_RET_SHORT;
               w_state_nx = S_DONE;
            end else begin
               w_ret_ld   = 1'b0;
               w_idx_clr  = 1'b1;
               w_state_nx = S_WRITE;
            end
         end
         S_WRITE: begin
            if (!bus.avmm_0_rw_waitrequest) begin
               if (w_last) begin
                  w_ret_ld   = 1'b1;
                  w_ret_nx   = {29'd0, w_n};
                  w_state_nx = S_DONE;
               end else begin
                  w_idx_inc  = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (!bus.stall) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Call arguments, byte index and result
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_str   <= '0;
         r_len   <= '0;
         r_value <= '0;
         r_idx   <= '0;
         r_ret   <= '0;
      end else begin
         if (w_accept) begin
            r_str   <= bus.str;
            r_len   <= bus.len;
            r_value <= bus.value;
         end
         if (w_idx_clr)      r_idx <= 2'd0;
         else if (w_idx_inc) r_idx <= r_idx + 2'd1;
         if (w_ret_ld)       r_ret <= w_ret_nx;
      end
   end

   // Outputs derive only from registered state, so they stay frozen while
   // waitrequest stalls a beat and fall to zero as soon as reset hits.
   assign w_write = (r_state == S_WRITE);
   assign w_addr  = r_str + ADDR_W'(r_idx);

   assign bus.busy                = (r_state != S_IDLE);
   assign bus.done                = (r_state == S_DONE);
   assign bus.returndata          = r_ret;
   assign bus.avmm_0_rw_write     = w_write;
   assign bus.avmm_0_rw_address   = w_write ? w_addr : '0;
   assign bus.avmm_0_rw_writedata = w_write ? {c_LANES{w_byte}} : '0;

   generate
      if (c_LANES > 1) begin : g_multi_lane
         localparam int c_LANE_W = $clog2(c_LANES);
         assign bus.avmm_0_rw_byteenable =
            w_write ? (c_LANES'(1) << w_addr[c_LANE_W-1:0]) : '0;
      end else begin : g_single_lane
         assign bus.avmm_0_rw_byteenable = w_write;
      end
   endgenerate
endmodule
`default_nettype wire

// File: tb/tb_utf8_putc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_utf8_putc
//  Description : Directed self-checking bench for utf8_putc. A posedge
//                monitor logs every accepted write beat; each scenario task
//                compares result, latency and the logged beats against
//                hand-computed UTF-8 encodings.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_utf8_putc;
   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   utf8_putc_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   utf8_putc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Accepted-beat log
   logic [63:0] log_addr[$];
   logic [7:0]  log_be[$];
   logic [63:0] log_data[$];

   always @(posedge clock) begin
      if (!reset && bus.avmm_0_rw_write && !bus.avmm_0_rw_waitrequest) begin
         log_addr.push_back(bus.avmm_0_rw_address);
         log_be.push_back(bus.avmm_0_rw_byteenable);
         log_data.push_back(bus.avmm_0_rw_writedata);
      end
   end

   // Per-call knobs and observations
   int          wait_n  = 0;
   int          stall_n = 0;
   logic [31:0] got_ret;
   int          got_lat;
   int          got_done;
   int          got_held;
   logic        held_ok;

   // Starts a call at the current negedge and runs until done drops again.
   // got_lat = k where done first appears in cycle T+k.
   task automatic call(input logic [63:0] s, input logic [31:0] l, input logic [31:0] v);
      int          k;
      logic [63:0] a0;
      logic [7:0]  b0;
      logic [63:0] d0;
      log_addr.delete(); log_be.delete(); log_data.delete();
      bus.str   = s;
      bus.len   = l;
      bus.value = v;
      bus.start = 1'b1;
      bus.stall = (stall_n > 0);
      bus.avmm_0_rw_waitrequest = 1'b0;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      k = 1; got_lat = -1; got_done = 0; got_held = 0; held_ok = 1'b1;
      got_ret = 32'h0; a0 = '0; b0 = '0; d0 = '0;
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_after_start: got %b want 1 (value %h)", bus.busy, v);
      end
      while (k < 60) begin
         if (bus.avmm_0_rw_write && log_addr.size() == 0 && got_held < wait_n) begin
            if (got_held == 0) begin
               a0 = bus.avmm_0_rw_address; b0 = bus.avmm_0_rw_byteenable;
               d0 = bus.avmm_0_rw_writedata;
            end else if (bus.avmm_0_rw_address !== a0 || bus.avmm_0_rw_byteenable !== b0 ||
                         bus.avmm_0_rw_writedata !== d0) begin
               held_ok = 1'b0;
            end
            bus.avmm_0_rw_waitrequest = 1'b1;
            got_held++;
         end else begin
            if (got_held > 0 && log_addr.size() == 0 &&
                (bus.avmm_0_rw_write !== 1'b1 || bus.avmm_0_rw_address !== a0 ||
                 bus.avmm_0_rw_byteenable !== b0 || bus.avmm_0_rw_writedata !== d0))
               held_ok = 1'b0;
            bus.avmm_0_rw_waitrequest = 1'b0;
         end
         if (bus.done) begin
            if (got_lat < 0) begin
               got_lat = k;
               got_ret = bus.returndata;
            end else if (bus.returndata !== got_ret) begin
               held_ok = 1'b0;
            end
            got_done++;
            if (got_done > stall_n) bus.stall = 1'b0;
         end else if (got_lat >= 0) begin
            break;
         end
         @(negedge clock);
         k++;
      end
      checks++;
      if (got_lat < 0 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL call_timeout: value %h got lat %0d done %b want completion", v, got_lat, bus.done);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.returndata !== 32'h0) begin
         failures++;
         $display("FAIL reset_handshake: busy %b done %b ret %h want 0 0 0", bus.busy, bus.done, bus.returndata);
      end
      checks++;
      if (bus.avmm_0_rw_write !== 1'b0 || bus.avmm_0_rw_address !== 64'h0 ||
          bus.avmm_0_rw_byteenable !== 8'h0 || bus.avmm_0_rw_writedata !== 64'h0) begin
         failures++;
         $display("FAIL reset_avmm: wr %b addr %h be %h data %h want all 0", bus.avmm_0_rw_write,
                  bus.avmm_0_rw_address, bus.avmm_0_rw_byteenable, bus.avmm_0_rw_writedata);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_ascii();
      call(64'h1000, 32'd8, 32'h41);
      checks++;
      if (got_ret !== 32'd1 || got_lat !== 3) begin
         failures++;
         $display("FAIL ascii_result: ret %h lat %0d want 1 3", got_ret, got_lat);
      end
      checks++;
      if (log_addr.size() != 1 || log_addr[0] !== 64'h1000 || log_be[0] !== 8'h01 ||
          log_data[0] !== 64'h4141_4141_4141_4141) begin
         failures++;
         $display("FAIL ascii_write: n %0d addr %h be %h data %h want 1 1000 01 41x8",
                  log_addr.size(), log_addr[0], log_be[0], log_data[0]);
      end
   endtask

   task automatic test_euro();
      logic [7:0] eb[3];
      logic [7:0] ebe[3];
      eb  = '{8'hE2, 8'h82, 8'hAC};
      ebe = '{8'h40, 8'h80, 8'h01};
      call(64'h1006, 32'd3, 32'h20AC);
      checks++;
      if (got_ret !== 32'd3 || got_lat !== 5 || log_addr.size() != 3) begin
         failures++;
         $display("FAIL euro_result: ret %h lat %0d beats %0d want 3 5 3", got_ret, got_lat, log_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_addr[i] !== 64'h1006 + 64'(i) || log_be[i] !== ebe[i] || log_data[i] !== {8{eb[i]}}) begin
               failures++;
               $display("FAIL euro_beat%0d: addr %h be %h data %h want %h %h %h", i, log_addr[i],
                        log_be[i], log_data[i], 64'h1006 + 64'(i), ebe[i], {8{eb[i]}});
            end
         end
      end
   endtask

   task automatic test_emoji();
      logic [7:0] eb[4];
      eb = '{8'hF0, 8'h9F, 8'h98, 8'h80};
      call(64'h3000, 32'd3, 32'h1F600);
      checks++;
      if (got_ret !== 32'hFFFF_FFFF || got_lat !== 2 || log_addr.size() != 0) begin
         failures++;
         $display("FAIL emoji_short: ret %h lat %0d beats %0d want ffffffff 2 0", got_ret, got_lat, log_addr.size());
      end
      call(64'h3000, 32'hFFFF_FFFF, 32'h41);
      checks++;
      if (got_ret !== 32'hFFFF_FFFF || log_addr.size() != 0) begin
         failures++;
         $display("FAIL negative_len: ret %h beats %0d want ffffffff 0", got_ret, log_addr.size());
      end
      call(64'h3000, 32'd4, 32'h1F600);
      checks++;
      if (got_ret !== 32'd4 || got_lat !== 6 || log_addr.size() != 4) begin
         failures++;
         $display("FAIL emoji_result: ret %h lat %0d beats %0d want 4 6 4", got_ret, got_lat, log_addr.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[i] !== 64'h3000 + 64'(i) || log_be[i] !== (8'h01 << i) || log_data[i] !== {8{eb[i]}}) begin
               failures++;
               $display("FAIL emoji_beat%0d: addr %h be %h data %h want byte %h", i, log_addr[i],
                        log_be[i], log_data[i], eb[i]);
            end
         end
      end
   endtask

   task automatic test_invalid_and_query();
      call(64'h1000, 32'd8, 32'h200000);
      checks++;
      if (got_ret !== 32'hFFFF_FFFE || got_lat !== 2 || log_addr.size() != 0) begin
         failures++;
         $display("FAIL invalid_value: ret %h lat %0d beats %0d want fffffffe 2 0", got_ret, got_lat, log_addr.size());
      end
      call(64'h0, 32'd0, 32'hFFFF_FFFF);
      checks++;
      if (got_ret !== 32'hFFFF_FFFE) begin
         failures++;
         $display("FAIL invalid_before_query: ret %h want fffffffe", got_ret);
      end
      call(64'h0, 32'd0, 32'h7FF);
      checks++;
      if (got_ret !== 32'd2 || got_lat !== 2 || log_addr.size() != 0) begin
         failures++;
         $display("FAIL query: ret %h lat %0d beats %0d want 2 2 0", got_ret, got_lat, log_addr.size());
      end
   endtask

   // Range edges; expected bytes packed lead byte first in the top octet.
   task automatic test_boundaries();
      logic [31:0] tv[8];
      logic [2:0]  tn[8];
      logic [31:0] tb[8];
      logic [7:0]  eb;
      tv = '{32'h7F, 32'h80, 32'h7FF, 32'h800, 32'hFFFF, 32'hD800, 32'h10000, 32'h1FFFFF};
      tn = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4};
      tb = '{32'h7F000000, 32'hC2800000, 32'hDFBF0000, 32'hE0A08000,
             32'hEFBFBF00, 32'hEDA08000, 32'hF0908080, 32'hF7BFBFBF};
      for (int t = 0; t < 8; t++) begin
         call(64'h4000 + 64'(t * 8), 32'd4, tv[t]);
         checks++;
         if (got_ret !== 32'(tn[t]) || log_addr.size() != int'(tn[t])) begin
            failures++;
            $display("FAIL bound_%h: ret %h beats %0d want %0d", tv[t], got_ret, log_addr.size(), tn[t]);
         end else begin
            for (int i = 0; i < int'(tn[t]); i++) begin
               eb = tb[t][31 - 8*i -: 8];
               checks++;
               if (log_data[i] !== {8{eb}}) begin
                  failures++;
                  $display("FAIL bound_%h_byte%0d: data %h want %h", tv[t], i, log_data[i], {8{eb}});
               end
            end
         end
      end
   endtask

   task automatic test_wrap();
      call(64'hFFFF_FFFF_FFFF_FFFE, 32'd3, 32'h20AC);
      checks++;
      if (got_ret !== 32'd3 || log_addr.size() != 3 || log_addr[2] !== 64'h0 || log_be[0] !== 8'h40 ||
          log_be[2] !== 8'h01 || log_addr[1] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         failures++;
         $display("FAIL addr_wrap: ret %h beats %0d addr2 %h be0 %h be2 %h want 3 3 0 40 01",
                  got_ret, log_addr.size(), log_addr[2], log_be[0], log_be[2]);
      end
   endtask

   task automatic test_waitrequest_stall();
      wait_n = 3; stall_n = 2;
      call(64'h5000, 32'd2, 32'hE9);
      wait_n = 0; stall_n = 0;
      checks++;
      if (got_ret !== 32'd2 || got_lat !== 7) begin
         failures++;
         $display("FAIL wait_result: ret %h lat %0d want 2 7", got_ret, got_lat);
      end
      checks++;
      if (held_ok !== 1'b1 || got_held !== 3) begin
         failures++;
         $display("FAIL wait_hold: stable %b held %0d want 1 3", held_ok, got_held);
      end
      checks++;
      if (got_done !== 3) begin
         failures++;
         $display("FAIL stall_done_cycles: got %0d want 3", got_done);
      end
      checks++;
      if (log_addr.size() != 2 || log_data[0] !== {8{8'hC3}} || log_data[1] !== {8{8'hA9}} ||
          log_be[0] !== 8'h01 || log_be[1] !== 8'h02) begin
         failures++;
         $display("FAIL wait_bytes: beats %0d d0 %h d1 %h want 2 C3x8 A9x8", log_addr.size(), log_data[0], log_data[1]);
      end
   endtask

   task automatic test_reset_midwrite();
      int k;
      log_addr.delete(); log_be.delete(); log_data.delete();
      bus.str = 64'h2000; bus.len = 32'd3; bus.value = 32'h20AC; bus.stall = 1'b0;
      bus.avmm_0_rw_waitrequest = 1'b0;
      bus.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      k = 0;
      while (!(log_addr.size() == 1 && bus.avmm_0_rw_write) && k < 20) begin
         @(negedge clock);
         k++;
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.returndata !== 32'h0 || bus.avmm_0_rw_write !== 1'b0 ||
          bus.avmm_0_rw_address !== 64'h0 || bus.avmm_0_rw_byteenable !== 8'h0 || bus.avmm_0_rw_writedata !== 64'h0) begin
         failures++;
         $display("FAIL midwrite_reset: busy %b done %b ret %h wr %b addr %h want all 0 (k %0d)",
                  bus.busy, bus.done, bus.returndata, bus.avmm_0_rw_write, bus.avmm_0_rw_address, k);
      end
      @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      checks++;
      if (log_addr.size() != 1 || bus.avmm_0_rw_write !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL midwrite_abandon: beats %0d wr %b busy %b want 1 0 0", log_addr.size(), bus.avmm_0_rw_write, bus.busy);
      end
      call(64'h6000, 32'd1, 32'h41);
      checks++;
      if (got_ret !== 32'd1 || got_lat !== 3 || log_addr.size() != 1 || log_addr[0] !== 64'h6000) begin
         failures++;
         $display("FAIL after_reset_call: ret %h lat %0d beats %0d want 1 3 1", got_ret, got_lat, log_addr.size());
      end
   endtask

   task automatic test_back_to_back();
      call(64'h7000, 32'd8, 32'h41);
      checks++;
      if (bus.busy !== 1'b0 || got_ret !== 32'd1) begin
         failures++;
         $display("FAIL b2b_first: busy %b ret %h want 0 1", bus.busy, got_ret);
      end
      call(64'h7010, 32'd8, 32'h20AC);
      checks++;
      if (got_ret !== 32'd3 || got_lat !== 5 || log_addr.size() != 3 || log_addr[0] !== 64'h7010) begin
         failures++;
         $display("FAIL b2b_second: ret %h lat %0d beats %0d want 3 5 3", got_ret, got_lat, log_addr.size());
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.stall = 1'b0; bus.str = '0; bus.len = '0; bus.value = '0;
      bus.avmm_0_rw_waitrequest = 1'b0;
      test_reset();
      test_ascii();
      test_euro();
      test_emoji();
      test_invalid_and_query();
      test_boundaries();
      test_wrap();
      test_waitrequest_stall();
      test_reset_midwrite();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
